// File: rtl/stack_pkg.sv
// Shared encodings for the stack access unit, SP unit and decoder:
// op codes, SP adjust codes and sequencer state names.
package stack_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_RTI  = 3'b101;
    localparam logic [2:0] OP_INT  = 3'b110;
    localparam logic [2:0] OP_NONE2 = 3'b111;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_DEC  = 2'b01;
    localparam logic [1:0] SP_INC  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_INT2    = 2'b01,
        S_RTI_PC  = 2'b10,
        S_RD_LAST = 2'b11
    } state_t;

endpackage

// File: rtl/stack_access_unit.sv
// Memory-stage sequencer for PUSH/POP/CALL/RET/RTI/INT. Strobes are driven
// combinationally from the current state; sp_q carries SP between the cycles of multi-access ops.
module stack_access_unit
    import stack_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [2:0]    op_code,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] pc_ret,
    input  logic [FW-1:0] flags_in,
    input  logic [AW-1:0] sp_in,
    input  logic          sp_not_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          accept,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [1:0]    sp_ctrl,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic          pc_load,
    output logic [AW-1:0] pc_out,
    output logic          flags_load,
    output logic [FW-1:0] flags_out
);

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [AW-1:0] sp_q, sp_nxt;
    logic          is_pop_q, is_pop_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            sp_q     <= '0;
            is_pop_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            sp_q     <= sp_nxt;
            is_pop_q <= is_pop_nxt;
        end
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        sp_nxt     = sp_q;
        is_pop_nxt = is_pop_q;
        accept     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        sp_ctrl    = SP_HOLD;
        pop_valid  = 1'b0;
        pop_data   = '0;
        pc_load    = 1'b0;
        pc_out     = '0;
        flags_load = 1'b0;
        flags_out  = '0;
        case (state)
            S_IDLE: begin
                accept = op_valid && (op_code != OP_NONE) && (op_code != OP_NONE2)
                         && !sp_not_ready;
                if (accept) begin
                    case (op_code)
                        OP_PUSH, OP_CALL, OP_INT: begin
                            mem_we    = 1'b1;
                            mem_addr  = sp_in;
                            mem_wdata = (op_code == OP_PUSH) ? push_data : DW'(pc_ret);
                            sp_ctrl   = SP_DEC;
                            sp_nxt    = sp_in - ONE;
                            if (op_code == OP_INT)
                                state_nxt = S_INT2;
                        end
                        default: begin
                            // POP, RET and RTI all begin by reading the slot above SP
                            mem_re     = 1'b1;
                            mem_addr   = sp_in + ONE;
                            sp_ctrl    = SP_INC;
                            sp_nxt     = sp_in + ONE;
                            is_pop_nxt = (op_code == OP_POP);
                            state_nxt  = (op_code == OP_RTI) ? S_RTI_PC : S_RD_LAST;
                        end
                    endcase
                end
            end
            S_INT2: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = DW'(flags_in);
                sp_ctrl   = SP_DEC;
                sp_nxt    = sp_q - ONE;
                state_nxt = S_IDLE;
            end
            S_RTI_PC: begin
                flags_load = 1'b1;
                flags_out  = mem_rdata[FW-1:0];
                mem_re     = 1'b1;
                mem_addr   = sp_q + ONE;
                sp_ctrl    = SP_INC;
                sp_nxt     = sp_q + ONE;
                is_pop_nxt = 1'b0;
                state_nxt  = S_RD_LAST;
            end
            default: begin
                if (is_pop_q) begin
                    pop_valid = 1'b1;
                    pop_data  = mem_rdata;
                end else begin
                    pc_load = 1'b1;
                    pc_out  = AW'(mem_rdata);
                end
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/stack_access_unit.md
Name: stack_access_unit

Overview:
- Memory-stage sequencer for stack instructions: PUSH, POP, CALL, RET, RTI and the hardware interrupt entry (INT).
- Consumes the bypassed stack pointer and its not-ready flag from the SP bypass unit.
- Drives data-memory address, data and enables, and emits the per-access SP increment/decrement code fed back as SP_Ex.
- Multi-cycle operations hold busy high so the hazard unit stalls the front of the pipe.

Parameters:
- AW, 8, data-memory address width and SP width.
- DW, 8, data word width.
- FW, 4, flags width (Z,N,C,V) saved and restored by INT/RTI.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  stack op present in the stage.
- op_code  in  3  000 NONE, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 RTI, 110 INT, 111 NONE.
- push_data  in  DW  register value for PUSH.
- pc_ret  in  AW  return PC saved by CALL/INT.
- flags_in  in  FW  CCR value saved by INT.
- sp_in  in  AW  bypassed SP.
- sp_not_ready  in  1  sp_in not yet valid.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_re.
- accept  out  1  op taken this cycle.
- busy  out  1  state != IDLE; stall request.
- mem_addr  out  AW  stack access address.
- mem_wdata  out  DW  write data.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- sp_ctrl  out  2  10 = SP+1, 01 = SP-1, 00 = hold; one pulse per access.
- pop_valid  out  1  pop_data valid (POP only).
- pop_data  out  DW  popped value.
- pc_load  out  1  redirect PC to pc_out.
- pc_out  out  AW  popped return PC.
- flags_load  out  1  restore CCR from flags_out.
- flags_out  out  FW  popped flags (mem_rdata[FW-1:0]).

Behaviour:
- Stack convention:
  - Grows downward. Push writes M[SP] then SP-1; pop reads M[SP+1] then SP+1.
  - All SP arithmetic is modulo 2^AW: 8'h00-1 = 8'hFF, 8'hFF+1 = 8'h00. No overflow flag.
- Internal register sp_q tracks SP across the cycles of a multi-cycle op.
- accept = op_valid & (op_code in 001..110) & ~sp_not_ready & state==IDLE. On accept, the first access uses sp_in directly and sp_q captures the post-access SP.
- While sp_not_ready is high, nothing is accepted, there is no memory strobe, and sp_ctrl = 00. The upstream stall holds the op.
- States and transitions:
  - IDLE:
    - PUSH: we, addr=sp_in, wdata=push_data, sp_ctrl=01; stay IDLE.
    - CALL: same with wdata=pc_ret; stay IDLE.
    - INT: we, addr=sp_in, wdata=pc_ret, sp_ctrl=01 -> INT2.
    - POP/RET: re, addr=sp_in+1, sp_ctrl=10 -> RD_LAST.
    - RTI: re, addr=sp_in+1, sp_ctrl=10 -> RTI_PC.
  - INT2: we, addr=sp_q, wdata={0,flags_in}, sp_ctrl=01 -> IDLE. Net SP change is -2.
  - RTI_PC: flags_load=1 with flags_out=mem_rdata; re, addr=sp_q+1, sp_ctrl=10 -> RD_LAST.
  - RD_LAST: POP gives pop_valid=1, pop_data=mem_rdata. RET/RTI give pc_load=1, pc_out=mem_rdata. -> IDLE.
- busy is combinational (state != IDLE). Single-cycle PUSH/CALL never raise busy. POP/RET are busy 1 cycle; RTI is busy 2 cycles; INT is busy 1 cycle.
- Strobes: mem_we and mem_re are never high together. All strobes and load pulses last exactly one cycle.
- Reset (rst=1 at a clk edge):
  - state=IDLE, sp_q=0, and every registered output clears to 0.
  - Reset mid-operation aborts the sequence; no further write, read or load follows.
- New ops are ignored while busy; upstream must hold the op until accept.

Decomposition:
- Shared package stack_pkg holds the op_code localparams (OP_NONE..OP_INT), the state encodings (S_IDLE, S_INT2, S_RTI_PC, S_RD_LAST), and the SP_INC=2'b10 / SP_DEC=2'b01 codes, shared with SP_Unit and the decoder.
- A single flat module; no sub-module is warranted.

Test Plan:
- sp_in=8'h80, PUSH with push_data=8'h5A -> same cycle: mem_we=1, mem_addr=8'h80, mem_wdata=8'h5A, sp_ctrl=01, busy=0.
- sp_in=8'h7F, POP, mem_rdata=8'hC3 next cycle -> c0: re, addr=8'h80, sp_ctrl=10, busy=1 (from the following cycle); c1: pop_valid=1, pop_data=8'hC3.
- sp_in=8'h00, INT with pc_ret=8'h42, flags_in=4'b1010 -> c0: write 8'h42 @8'h00; c1: write 8'h0A @8'hFF (wrap); two sp_ctrl=01 pulses.
- sp_in=8'hFD, RTI, memory M[FE]=8'h0A, M[FF]=8'h42 -> c1: flags_load=1, flags_out=4'hA, addr=8'hFF; c2: pc_load=1, pc_out=8'h42.
- sp_not_ready=1 for 2 cycles with PUSH held -> no accept and no strobes; accept and write on the cycle it drops.
- rst=1 during RTI_PC -> next cycle state IDLE, all outputs 0, no pc_load issued.
